// File: rtl/trg_seq_pkg.sv
// Shared constants and types for the internal trigger sequencer.
package trg_seq_pkg;

    // Register map (8-bit address, 16-bit data)
    localparam logic [7:0] TRGSEQ_STATUS    = 8'h00;
    localparam logic [7:0] TRGSEQ_CTRL      = 8'h01;
    localparam logic [7:0] TRGSEQ_CMD       = 8'h02;
    localparam logic [7:0] TRGSEQ_NTRG_LO   = 8'h03;
    localparam logic [7:0] TRGSEQ_NTRG_HI   = 8'h04;
    localparam logic [7:0] TRGSEQ_PERIOD_LO = 8'h05;
    localparam logic [7:0] TRGSEQ_PERIOD_HI = 8'h06;
    localparam logic [7:0] TRGSEQ_DELAY_LO  = 8'h07;
    localparam logic [7:0] TRGSEQ_DELAY_HI  = 8'h08;
    localparam logic [7:0] TRGSEQ_SENT_LO   = 8'h09;
    localparam logic [7:0] TRGSEQ_SENT_HI   = 8'h0A;
    localparam logic [7:0] TRGSEQ_ACC_LO    = 8'h0B;
    localparam logic [7:0] TRGSEQ_ACC_HI    = 8'h0C;

    localparam logic [15:0] TRGSEQ_RD_DEFAULT = 16'hF002;

    // CMD register codes
    localparam logic [15:0] TRGSEQ_CMD_START = 16'h0001;
    localparam logic [15:0] TRGSEQ_CMD_STOP  = 16'h0002;

    // Encoding is visible in STATUS[2:1]
    typedef enum logic [1:0] {
        SeqIdle  = 2'd0,
        SeqDelay = 2'd1,
        SeqFire  = 2'd2,
        SeqWait  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/trg_seq_if.sv
// Register bus shared by the sequencer and its host.
interface trg_seq_if;
    logic        reg_we;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;

    modport master (output reg_we, output reg_addr, output reg_wdata, input reg_rdata);
    modport slave  (input reg_we, input reg_addr, input reg_wdata, output reg_rdata);
endinterface

// File: rtl/trg_seq_timer.sv
// Loadable down-counter shared by the DELAY and WAIT phases.
module trg_seq_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load wins over decrement
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/trg_seq.sv
// Internal trigger sequencer: programmable soft-trigger pulse train with statistics.
module trg_seq
    import trg_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    trg_seq_if.slave  bus,
    input  logic      bsy_i,
    input  logic      trg_acc_i,
    output logic      softtrg_o,
    output logic      running_o,
    output logic      done_o
);

    seq_state_e       state_q, state_d;
    logic             wait_bsy_q, cont_q;
    logic [CNT_W-1:0] ntrg_q, period_q, delay_q, sent_q, acc_q;
    logic             softtrg_q, done_q;
    logic [1:0]       tail_q;

    logic             cmd_wr, start, stop;
    logic             fire, finish, start_ok;
    logic             tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0] tmr_val, period_m1;

    function automatic logic [CNT_W-1:0] put_lo(logic [CNT_W-1:0] old, logic [15:0] d);
        logic [31:0] w;
        w       = 32'(old);
        w[15:0] = d;
        return w[CNT_W-1:0];
    endfunction

    // Hi-half writes only reach bits above 15 that actually exist
    function automatic logic [CNT_W-1:0] put_hi(logic [CNT_W-1:0] old, logic [15:0] d);
        logic [31:0] w;
        w        = 32'(old);
        w[31:16] = d;
        return w[CNT_W-1:0];
    endfunction

    assign cmd_wr    = bus.reg_we && (bus.reg_addr == TRGSEQ_CMD);
    assign start     = cmd_wr && (bus.reg_wdata == TRGSEQ_CMD_START);
    assign stop      = cmd_wr && (bus.reg_wdata == TRGSEQ_CMD_STOP);
    assign period_m1 = (period_q == '0) ? '0 : period_q - CNT_W'(1);

    trg_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (tmr_load),
        .en_i       (tmr_en),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Next-state and timer control; FIRE is a state so the pulse edge is the cycle after
    // the timer hits zero, hence WAIT is loaded one short of the period.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;
        fire     = 1'b0;
        finish   = 1'b0;
        start_ok = 1'b0;
        if (stop) begin
            state_d = SeqIdle;
        end else begin
            unique case (state_q)
                SeqIdle: begin
                    if (start) begin
                        start_ok = 1'b1;
                        if (!cont_q && (ntrg_q == '0)) begin
                            finish = 1'b1;
                        end else begin
                            state_d  = SeqDelay;
                            tmr_load = 1'b1;
                            tmr_val  = delay_q;
                        end
                    end
                end
                SeqDelay, SeqWait: begin
                    if (tmr_zero) state_d = SeqFire;
                    else          tmr_en  = 1'b1;
                end
                SeqFire: begin
                    if (!(wait_bsy_q && bsy_i)) begin
                        fire = 1'b1;
                        if (!cont_q && (sent_q + CNT_W'(1) == ntrg_q)) begin
                            finish  = 1'b1;
                            state_d = SeqIdle;
                        end else if (period_m1 != '0) begin
                            tmr_load = 1'b1;
                            tmr_val  = period_m1 - CNT_W'(1);
                            state_d  = SeqWait;
                        end
                    end
                end
                default: state_d = SeqIdle;
            endcase
        end
    end

    // State, pulse outputs and the post-completion acceptance window
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= SeqIdle;
            softtrg_q <= 1'b0;
            done_q    <= 1'b0;
            tail_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            softtrg_q <= fire;
            done_q    <= finish;
            tail_q    <= {tail_q[0], fire && finish};
        end
    end

    // Statistics counters; the tail window catches the last trigger's late acceptance
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sent_q <= '0;
            acc_q  <= '0;
        end else if (start_ok) begin
            sent_q <= '0;
            acc_q  <= '0;
        end else begin
            if (fire) sent_q <= sent_q + CNT_W'(1);
            if (trg_acc_i && (running_o || (tail_q != 2'b00))) acc_q <= acc_q + CNT_W'(1);
        end
    end

    // Configuration registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_bsy_q <= 1'b0;
            cont_q     <= 1'b0;
            ntrg_q     <= '0;
            period_q   <= '0;
            delay_q    <= '0;
        end else if (bus.reg_we) begin
            case (bus.reg_addr)
                TRGSEQ_CTRL: begin
                    wait_bsy_q <= bus.reg_wdata[0];
                    cont_q     <= bus.reg_wdata[1];
                end
                TRGSEQ_NTRG_LO:   ntrg_q   <= put_lo(ntrg_q, bus.reg_wdata);
                TRGSEQ_NTRG_HI:   ntrg_q   <= put_hi(ntrg_q, bus.reg_wdata);
                TRGSEQ_PERIOD_LO: period_q <= put_lo(period_q, bus.reg_wdata);
                TRGSEQ_PERIOD_HI: period_q <= put_hi(period_q, bus.reg_wdata);
                TRGSEQ_DELAY_LO:  delay_q  <= put_lo(delay_q, bus.reg_wdata);
                TRGSEQ_DELAY_HI:  delay_q  <= put_hi(delay_q, bus.reg_wdata);
                default: ;
            endcase
        end
    end

    // Combinational readback
    always_comb begin
        logic [31:0] ntrg32, period32, delay32, sent32, acc32;
        ntrg32        = 32'(ntrg_q);
        period32      = 32'(period_q);
        delay32       = 32'(delay_q);
        sent32        = 32'(sent_q);
        acc32         = 32'(acc_q);
        bus.reg_rdata = TRGSEQ_RD_DEFAULT;
        case (bus.reg_addr)
            TRGSEQ_STATUS:    bus.reg_rdata = {13'b0, state_q, running_o};
            TRGSEQ_CTRL:      bus.reg_rdata = {14'b0, cont_q, wait_bsy_q};
            TRGSEQ_NTRG_LO:   bus.reg_rdata = ntrg32[15:0];
            TRGSEQ_NTRG_HI:   bus.reg_rdata = ntrg32[31:16];
            TRGSEQ_PERIOD_LO: bus.reg_rdata = period32[15:0];
            TRGSEQ_PERIOD_HI: bus.reg_rdata = period32[31:16];
            TRGSEQ_DELAY_LO:  bus.reg_rdata = delay32[15:0];
            TRGSEQ_DELAY_HI:  bus.reg_rdata = delay32[31:16];
            TRGSEQ_SENT_LO:   bus.reg_rdata = sent32[15:0];
            TRGSEQ_SENT_HI:   bus.reg_rdata = sent32[31:16];
            TRGSEQ_ACC_LO:    bus.reg_rdata = acc32[15:0];
            TRGSEQ_ACC_HI:    bus.reg_rdata = acc32[31:16];
            default: ;
        endcase
    end

    assign running_o = (state_q != SeqIdle);
    assign softtrg_o = softtrg_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_trg_seq.sv
// Directed bench for trg_seq: pulse timing, busy deferral, stop, statistics and reset.
module tb_trg_seq;
    import trg_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bsy = 1'b0;
    logic loop_en = 1'b0;
    logic acc_fb = 1'b0;
    logic softtrg, running, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e;
    int pulses[$];
    int dones[$];

    trg_seq_if bus ();

    trg_seq #(.CNT_W(32)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .bus       (bus),
        .bsy_i     (bsy),
        .trg_acc_i (acc_fb),
        .softtrg_o (softtrg),
        .running_o (running),
        .done_o    (done)
    );

    always #5 clk = ~clk;

    // Cycle index of each rising edge and the edges at which pulses appear
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (softtrg) pulses.push_back(cyc);
        if (done) dones.push_back(cyc);
    end

    // Acceptance echo: one flop behind softtrg
    always @(posedge clk) acc_fb <= loop_en & softtrg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.reg_addr = a;
        bus.reg_wdata = d;
        bus.reg_we = 1'b1;
        @(negedge clk);
        bus.reg_we = 1'b0;
    endtask

    task automatic rd_now(input logic [7:0] a, input logic [15:0] exp, input string tag);
        bus.reg_addr = a;
        #1;
        chk(tag, {16'b0, bus.reg_rdata}, {16'b0, exp});
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] exp, input string tag);
        @(negedge clk);
        rd_now(a, exp, tag);
    endtask

    task automatic cfg(input logic [15:0] ctrl, input logic [15:0] ntrg,
                       input logic [15:0] period, input logic [15:0] delay);
        wr(TRGSEQ_CTRL, ctrl);
        wr(TRGSEQ_NTRG_LO, ntrg);
        wr(TRGSEQ_PERIOD_LO, period);
        wr(TRGSEQ_DELAY_LO, delay);
        pulses.delete();
        dones.delete();
    endtask

    initial begin
        bus.reg_we = 1'b0;
        bus.reg_addr = 8'h00;
        bus.reg_wdata = 16'h0000;
        #1;
        chk("rst_softtrg", {31'b0, softtrg}, 32'd0);
        chk("rst_running", {31'b0, running}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(TRGSEQ_STATUS, 16'h0000, "rst_status");
        rd(8'h3F, 16'hF002, "unmapped_read");

        // Hi-half write only touches the upper bits
        wr(TRGSEQ_NTRG_LO, 16'h1234);
        wr(TRGSEQ_NTRG_HI, 16'h0001);
        rd(TRGSEQ_NTRG_HI, 16'h0001, "ntrg_hi");
        rd(TRGSEQ_NTRG_LO, 16'h1234, "ntrg_lo_kept");
        wr(TRGSEQ_NTRG_HI, 16'h0000);

        // 1: DELAY=5 PERIOD=10 NTRG=3, acceptance looped back
        cfg(16'h0000, 16'd3, 16'd10, 16'd5);
        loop_en = 1'b1;
        wr(TRGSEQ_CMD, TRGSEQ_CMD_START);
        e = cyc;
        rd_now(TRGSEQ_STATUS, 16'h0003, "t1_status_delay");
        repeat (40) @(negedge clk);
        chk("t1_count", pulses.size(), 32'd3);
        chk("t1_p0", pulses[0], e + 7);
        chk("t1_p1", pulses[1], e + 17);
        chk("t1_p2", pulses[2], e + 27);
        chk("t1_done_cnt", dones.size(), 32'd1);
        chk("t1_done_at", dones[0], e + 27);
        chk("t1_running", {31'b0, running}, 32'd0);
        rd(TRGSEQ_SENT_LO, 16'd3, "t1_sent");
        rd(TRGSEQ_SENT_HI, 16'd0, "t1_sent_hi");
        rd(TRGSEQ_ACC_LO, 16'd3, "t1_acc");
        rd(TRGSEQ_STATUS, 16'h0000, "t1_status_idle");
        loop_en = 1'b0;

        // 2: PERIOD 0 and 1 both give back-to-back pulses
        for (int p = 0; p < 2; p++) begin
            cfg(16'h0000, 16'd4, 16'(p), 16'd0);
            wr(TRGSEQ_CMD, TRGSEQ_CMD_START);
            e = cyc;
            repeat (12) @(negedge clk);
            chk($sformatf("t2_p%0d_count", p), pulses.size(), 32'd4);
            chk($sformatf("t2_p%0d_first", p), pulses[0], e + 2);
            chk($sformatf("t2_p%0d_last", p), pulses[3], e + 5);
            chk($sformatf("t2_p%0d_done", p), dones[0], e + 5);
        end

        // 3: busy deferral with wait_bsy=1, then ignored with wait_bsy=0
        for (int w = 1; w >= 0; w--) begin
            cfg(16'(w), 16'd3, 16'd10, 16'd0);
            wr(TRGSEQ_CMD, TRGSEQ_CMD_START);
            e = cyc;
            repeat (5) @(negedge clk);
            bsy = 1'b1;
            repeat (20) @(negedge clk);
            bsy = 1'b0;
            repeat (20) @(negedge clk);
            chk($sformatf("t3_w%0d_count", w), pulses.size(), 32'd3);
            chk($sformatf("t3_w%0d_p0", w), pulses[0], e + 2);
            chk($sformatf("t3_w%0d_p1", w), pulses[1], (w == 1) ? e + 26 : e + 12);
            chk($sformatf("t3_w%0d_p2", w), pulses[2], (w == 1) ? e + 36 : e + 22);
        end

        // 4: continuous, stop after five pulses, restart clears SENT
        cfg(16'h0002, 16'd0, 16'd4, 16'd0);
        wr(TRGSEQ_CMD, TRGSEQ_CMD_START);
        e = cyc;
        repeat (17) @(negedge clk);
        wr(TRGSEQ_CMD, TRGSEQ_CMD_STOP);
        repeat (12) @(negedge clk);
        chk("t4_count", pulses.size(), 32'd5);
        chk("t4_p4", pulses[4], e + 18);
        chk("t4_no_done", dones.size(), 32'd0);
        rd(TRGSEQ_SENT_LO, 16'd5, "t4_sent");
        rd(TRGSEQ_STATUS, 16'h0000, "t4_status");
        wr(TRGSEQ_CMD, 16'h0007);
        rd(TRGSEQ_STATUS, 16'h0000, "t4_bad_cmd");
        wr(TRGSEQ_CMD, TRGSEQ_CMD_START);
        rd_now(TRGSEQ_SENT_LO, 16'd0, "t4_restart_sent");
        wr(TRGSEQ_CMD, TRGSEQ_CMD_STOP);

        // 5: NTRG=0 finite run, then START while running
        cfg(16'h0000, 16'd0, 16'd10, 16'd5);
        wr(TRGSEQ_CMD, TRGSEQ_CMD_START);
        e = cyc;
        repeat (10) @(negedge clk);
        chk("t5_no_pulse", pulses.size(), 32'd0);
        chk("t5_done_cnt", dones.size(), 32'd1);
        chk("t5_done_at", dones[0], e);
        cfg(16'h0000, 16'd3, 16'd10, 16'd5);
        wr(TRGSEQ_CMD, TRGSEQ_CMD_START);
        e = cyc;
        wr(TRGSEQ_CMD, TRGSEQ_CMD_START);
        repeat (35) @(negedge clk);
        chk("t5_count", pulses.size(), 32'd3);
        chk("t5_p0", pulses[0], e + 7);
        chk("t5_p2", pulses[2], e + 27);

        // 6: asynchronous reset in WAIT
        cfg(16'h0001, 16'd3, 16'd10, 16'd0);
        wr(TRGSEQ_CMD, TRGSEQ_CMD_START);
        repeat (3) @(negedge clk);
        chk("t6_running_before", {31'b0, running}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_running", {31'b0, running}, 32'd0);
        chk("t6_softtrg", {31'b0, softtrg}, 32'd0);
        chk("t6_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(TRGSEQ_NTRG_LO, 16'd0, "t6_ntrg");
        rd(TRGSEQ_PERIOD_LO, 16'd0, "t6_period");
        rd(TRGSEQ_CTRL, 16'd0, "t6_ctrl");
        rd(TRGSEQ_SENT_LO, 16'd0, "t6_sent");
        rd(TRGSEQ_STATUS, 16'd0, "t6_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
